// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned DATA_BITS  = 8;

  // Even parity bit for a data byte (the bit that makes the total count of ones even).
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO, DEPTH x 8. Head entry is presented combinationally.
// Pointers carry one extra MSB so full and empty are distinguishable.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        empty;
  logic        do_push;
  logic        do_pop;

  assign empty  = (wptr_q == rptr_q);
  assign full_o = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is accepted then.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full_o | do_pop);

  assign valid_o = ~empty;
  assign data_o  = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];

  // Pointer next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage; contents are don't-care while not covered by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, 16x oversampled, with a show-ahead receive FIFO.
// Optional build macro UART_RX_PARITY_EN: adds an even parity bit (8E1), par_err goes live and
// bytes failing parity are discarded. Without it par_err is tied 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic [DIV_W-1:0] div,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             par_err,
  input  logic             err_clr,
  output logic             busy
);

  localparam logic [3:0] SC_MID   = 4'(MID_SAMPLE);
  localparam logic [3:0] SC_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic             rx_meta_q, rxs_q;
  rx_state_t        state_q, state_d;
  logic [3:0]       sc_q, sc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             tick;
  logic             push;
  logic             set_ferr;
  logic             pop;
  logic             fifo_full;
`ifdef UART_RX_PARITY_EN
  logic             par_err_q, par_err_d;
  logic             par_bad_q, par_bad_d;
  logic             set_perr;
`endif

  // Two-flop synchroniser for the asynchronous pad input; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  assign tick = (state_q != IDLE) && (tick_cnt_q == '0);

  // Receive FSM next-state, tick generator and sample counter.
  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    push       = 1'b0;
    set_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    set_perr   = 1'b0;
`endif

    if (tick) begin
      tick_cnt_d = div_q;
      sc_d       = sc_q + 4'd1;
    end else if (state_q != IDLE) begin
      tick_cnt_d = tick_cnt_q - DIV_W'(1);
    end

    unique case (state_q)
      // IDLE is only entered with rxs high, so a low level here is a falling edge.
      IDLE: begin
        if (!rxs_q) begin
          state_d    = START;
          sc_d       = 4'd0;
          bit_d      = 3'd0;
          div_d      = div;
          tick_cnt_d = div;
`ifdef UART_RX_PARITY_EN
          par_bad_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (tick && sc_q == SC_MID) begin
          sc_d    = 4'd0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && sc_q == SC_LAST) begin
          shreg_d = {rxs_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && sc_q == SC_LAST) begin
          if (rxs_q != even_parity(shreg_q)) begin
            set_perr  = 1'b1;
            par_bad_d = 1'b1;
          end
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && sc_q == SC_LAST) begin
          if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
            push = ~par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            set_ferr = 1'b1;
            state_d  = BREAK;
          end
        end
      end
      // Hold off until the line returns high so a long break is not seen as new starts.
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = rd_valid & rd_ready;

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_comb begin
    frame_err_d = set_ferr | (frame_err_q & ~err_clr);
    overrun_d   = (push & fifo_full & ~pop) | (overrun_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
    par_err_d   = set_perr | (par_err_q & ~err_clr);
`endif
  end

  // FSM, counters, shift register and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sc_q        <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      tick_cnt_q  <= '0;
      div_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
      par_bad_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      tick_cnt_q  <= tick_cnt_d;
      div_q       <= div_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
      par_bad_q   <= par_bad_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (shreg_q),
    .pop_i   (pop),
    .data_o  (rd_data),
    .valid_o (rd_valid),
    .full_o  (fifo_full)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule
